simple_run_ctrl: RTL
====================

// Module: simple_run_ctrl
// PURPOSE
//   Run sequencer for the counter/shifter test datapath (2b counter, 127b shifter, wide mirror bus).
//   Accepts commands over a valid/ready port. Issues a one-cycle synchronous clear, then N step pulses
//   with a programmable idle gap between steps, then reports completion.
//   Sits between the integration-test stimulus driver and the datapath step-enable/clear inputs,
//   and produces deterministic, bursty waveforms for trace-writer tests.
// PARAMETERS
//   LEN_W  16  width of run length and step counter (max run = 2**LEN_W-1 steps)
//   GAP_W  4   width of inter-step gap (0..2**GAP_W-1 idle cycles)
// PORTS
//   clk         in   1      clock, rising edge
//   rst_n       in   1      asynchronous, active-low reset
//   cmd_valid   in   1      command present
//   cmd_ready   out  1      command accepted when cmd_valid && cmd_ready
//   cmd_op      in   2      run_op_e: NOP=0, START=1, STOP=2, STEP=3
//   cmd_len     in   LEN_W  step count for START (sampled at accept)
//   cmd_gap     in   GAP_W  idle cycles between steps for START (sampled at accept)
//   dp_clr      out  1      synchronous clear pulse to datapath
//   dp_step     out  1      advance datapath by one step this cycle
//   busy        out  1      state != IDLE
//   done        out  1      one-cycle pulse: run finished or aborted
//   aborted     out  1      valid with done; 1 = run ended by STOP
//   steps_done  out  LEN_W  steps issued in current/last run
// BEHAVIOUR
//   - Reset values: state=IDLE; cmd_ready=1, all other outputs 0, steps_done=0.
//   - All outputs decode from registered state/counters only; no comb path cmd_* -> outputs except cmd_ready.
//   - States (run_state_e): IDLE, CLEAR, RUN, GAP, DONE.
//   - cmd_ready=1 in IDLE/RUN/GAP; 0 in CLEAR/DONE.
//   - IDLE: START accepted at cycle t -> latch len/gap, steps_done<=0, CLEAR at t+1.
//     STEP -> dp_step=1 at t+1 only; no clear; steps_done+1; state stays IDLE; no done.
//     NOP and STOP are accepted and ignored.
//   - CLEAR: dp_clr=1 for exactly 1 cycle.
//     Next state: len==0 -> DONE (aborted=0); else RUN.
//   - RUN: dp_step=1 for 1 cycle; steps_done increments (visible next cycle).
//     If this is step len -> DONE; else gap==0 -> RUN; else GAP with gap counter loaded with gap.
//   - GAP: dp_step=0; gap counter decrements each cycle; when it hits 1 -> RUN. Step period = gap+1 cycles.
//   - DONE: done=1 for 1 cycle, aborted per cause; then IDLE.
//   - STOP in RUN/GAP accepted at t -> DONE at t+1 (aborted=1).
//     A dp_step asserted in cycle t still counts. START/STEP/NOP in RUN/GAP are accepted and dropped.
//   - Counter widths: steps_done never wraps (bounded by len ≤ 2**LEN_W-1). Gap counter is GAP_W bits.
//   - steps_done holds its value after DONE until the next START or IDLE STEP (STEP counting wraps modulo 2**LEN_W).
//   - Reset mid-run: immediate return to reset values; no done pulse.
// STRUCTURE
//   - Package simple_run_pkg: typedef enum logic [1:0] run_op_e; typedef enum logic [2:0] run_state_e.
//   - Single module; step/gap counters inline. No sub-module needed.
// TESTING
//   1. Reset: rst_n low mid-RUN (len=10, 4 steps in) -> next edge all outputs 0, cmd_ready=1, no done.
//   2. START len=3 gap=0 accepted at t -> dp_clr at t+1, dp_step t+2..t+4, done t+5, aborted=0, steps_done=3.
//   3. START len=2 gap=2 at t -> dp_clr t+1, dp_step t+2 and t+5, done t+6.
//   4. START len=100 gap=0, STOP accepted on 5th step cycle -> done next cycle, aborted=1, steps_done=5.
//   5. START len=0 at t -> dp_clr t+1, done t+2, no dp_step, steps_done=0.
//   6. IDLE STEP x3 back-to-back -> 3 dp_step pulses, no dp_clr, no done, busy=0, steps_done=3;
//      START during CLEAR held off by cmd_ready=0.

Source files
------------

// File: rtl/simple_run_pkg.sv
// Shared types for the run sequencer: command opcodes and sequencer states.
package simple_run_pkg;

   typedef enum logic [1:0] {
      OP_NOP   = 2'd0,
      OP_START = 2'd1,
      OP_STOP  = 2'd2,
      OP_STEP  = 2'd3
   } run_op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RUN   = 3'd2,
      ST_GAP   = 3'd3,
      ST_DONE  = 3'd4
   } run_state_e;

endpackage

// File: rtl/simple_run_ctrl.sv
// Run sequencer: one clear pulse, then len step pulses spaced gap idle cycles apart,
// then a done pulse. STOP aborts a run; STEP in IDLE issues a single stand-alone pulse.
module simple_run_ctrl #(
   parameter int unsigned LEN_W = 16,
   parameter int unsigned GAP_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [GAP_W-1:0] cmd_gap,
   output logic             dp_clr,
   output logic             dp_step,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [LEN_W-1:0] steps_done
);
   import simple_run_pkg::*;

   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
   localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

   run_state_e       state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] steps_q, steps_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [GAP_W-1:0] cnt_q, cnt_d;
   logic             abort_q, abort_d;
   logic             istep_q, istep_d;
   run_op_e          op;
   logic             accept;

   assign op     = run_op_e'(cmd_op);
   assign accept = cmd_valid && cmd_ready;

   // Every output is a decode of registered state; only cmd_ready is looked at combinationally.
   assign cmd_ready  = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_GAP);
   assign busy       = (state_q != ST_IDLE);
   assign dp_clr     = (state_q == ST_CLEAR);
   assign dp_step    = (state_q == ST_RUN) || istep_q;
   assign done       = (state_q == ST_DONE);
   assign aborted    = (state_q == ST_DONE) && abort_q;
   assign steps_done = steps_q;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      gap_d   = gap_q;
      cnt_d   = cnt_q;
      abort_d = abort_q;
      istep_d = 1'b0;
      steps_d = dp_step ? steps_q + LEN_ONE : steps_q;

      unique case (state_q)
         ST_IDLE: begin
            if (accept && op == OP_START) begin
               len_d   = cmd_len;
               gap_d   = cmd_gap;
               steps_d = '0;
               abort_d = 1'b0;
               state_d = ST_CLEAR;
            end else if (accept && op == OP_STEP) begin
               istep_d = 1'b1;
            end
         end
         ST_CLEAR: begin
            abort_d = 1'b0;
            state_d = (len_q == '0) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            // A STOP landing on the final step still reports the run as aborted.
            if (accept && op == OP_STOP) begin
               abort_d = 1'b1;
               state_d = ST_DONE;
            end else if (steps_q + LEN_ONE == len_q) begin
               state_d = ST_DONE;
            end else if (gap_q != '0) begin
               cnt_d   = gap_q;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (accept && op == OP_STOP) begin
               abort_d = 1'b1;
               state_d = ST_DONE;
            end else if (cnt_q == GAP_ONE) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - GAP_ONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         gap_q   <= '0;
         cnt_q   <= '0;
         steps_q <= '0;
         abort_q <= 1'b0;
         istep_q <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         gap_q   <= gap_d;
         cnt_q   <= cnt_d;
         steps_q <= steps_d;
         abort_q <= abort_d;
         istep_q <= istep_d;
      end
   end

endmodule
